// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between eight requesters and decoder_rr_arbiter.
`timescale 1ns/1ps
interface decoder_rr_arbiter_if;
  logic [7:0] req;
  logic       rel;
  logic [7:0] grant;
  logic [2:0] grant_idx;
  logic       busy;
  logic       timeout;

  modport master (output req, output rel,
                  input grant, input grant_idx, input busy, input timeout);
  modport slave  (input req, input rel,
                  output grant, output grant_idx, output busy, output timeout);
endinterface

// File: rtl/decoder_rr_arbiter.sv
// Eight-way round-robin arbiter with a one-hot grant decoded from the owner index.
// Optional hold limit with forced release is enabled by defining ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module decoder_rr_arbiter #(
  parameter int HOLD_MAX = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  decoder_rr_arbiter_if.slave  bus
);

  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("decoder_rr_arbiter: HOLD_MAX must be in 1..255");
  end

  typedef enum logic {IDLE, OWN} state_t;

  state_t     state;
  logic [2:0] ptr;
  logic [2:0] win;

  // Search starts one past the last owner and wraps, so each requester waits at most seven grants.
  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] p);
    logic [2:0] res;
    logic [2:0] idx;
    logic       found;
    res   = p;
    found = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      idx = p + 3'(k);
      if (!found && r[idx]) begin
        res   = idx;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [7:0] dec3to8(input logic [2:0] sel, input logic en);
    return en ? (8'b1 << sel) : 8'b0;
  endfunction

  always_comb win = rr_pick(bus.req, ptr);

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 3'd7;
      bus.grant_idx <= 3'd0;
      bus.grant     <= 8'h00;
      bus.busy      <= 1'b0;
      bus.timeout   <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      cnt           <= 8'd0;
`endif
    end else begin
      bus.timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (|bus.req) begin
            state         <= OWN;
            bus.grant_idx <= win;
            bus.grant     <= dec3to8(win, 1'b1);
            bus.busy      <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            cnt           <= 8'd0;
`endif
          end else begin
            bus.grant <= 8'h00;
            bus.busy  <= 1'b0;
          end
        end
        OWN: begin
          // A dropped request is treated exactly like an explicit release.
          if (bus.rel || !bus.req[bus.grant_idx]) begin
            state     <= IDLE;
            ptr       <= bus.grant_idx;
            bus.grant <= 8'h00;
            bus.busy  <= 1'b0;
          end
`ifdef ARB_TIMEOUT_EN
          else if (cnt == HOLD_LAST) begin
            state       <= IDLE;
            ptr         <= bus.grant_idx;
            bus.grant   <= 8'h00;
            bus.busy    <= 1'b0;
            bus.timeout <= 1'b1;
          end else if (cnt != 8'hFF) begin
            cnt <= cnt + 8'd1;
          end
`endif
        end
        default: begin
          state     <= IDLE;
          bus.grant <= 8'h00;
          bus.busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
